oled_init_seq: RTL and testbench
================================

Name: oled_init_seq

Overview:
- Sequencer that walks the OLED command ROM (41 init/config bytes, SSD1306-style) and streams its contents as one I2C write frame through the byte-level I2C master.
- Frame layout: slave address byte, control byte, then ROM bytes 0..CMD_COUNT-1, with STOP after the last byte.
- Sits between the top-level power-up/start logic and the I2C master. Handles power-up delay, per-byte handshake, NACK retry and done/error reporting.

Parameters:
- CMD_COUNT, 41: number of ROM bytes sent; legal range 1..128.
- SLAVE_ADDR, 7'h3C: 7-bit I2C device address.
- CTRL_BYTE, 8'h00: control byte (Co=0, D/C#=0, command stream).
- PWR_WAIT, 16: cycles to wait after start before the first byte; legal range 1..2^20.
- RETRY_MAX, 3: maximum frame restarts after a NACK; legal range 0..3.

Ports:
- ck, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle request to run the init sequence; ignored unless state is IDLE, DONE or ERROR.
- rom_addr, output, 7: command ROM address.
- rom_data, input, 8: ROM output, combinational (same cycle as rom_addr).
- tx_valid, output, 1: byte offered to the I2C master.
- tx_data, output, 8: byte value.
- tx_first, output, 1: generate START before this byte.
- tx_last, output, 1: generate STOP after this byte.
- tx_ready, input, 1: master accepts the byte when tx_valid & tx_ready.
- tx_done, input, 1: one-cycle pulse when the byte's ACK slot completes.
- tx_nack, input, 1: qualified by tx_done; 1 means the slave NACKed.
- busy, output, 1: high in every state except IDLE, DONE and ERROR.
- init_done, output, 1: level; whole frame ACKed.
- init_err, output, 1: level; retries exhausted.
- retry_cnt, output, 2: number of restarts used in the current run.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; idx=0; wait counter=0.
  - All outputs 0: rom_addr=0, tx_valid=0, tx_data=0, tx_first=0, tx_last=0, busy=0, init_done=0, init_err=0, retry_cnt=0.
- Reset asserted mid-frame aborts immediately. No STOP is issued; the I2C master is reset from the same net.
- States:
  - IDLE/DONE/ERROR + start: clear init_done, init_err and retry_cnt; load wait counter=PWR_WAIT-1; go to PWR.
  - PWR: decrement each cycle; at 0 go to ADDR.
  - ADDR: tx_valid=1, tx_data={SLAVE_ADDR,1'b0}, tx_first=1. On handshake go to WACK with next=CTRL.
  - CTRL: tx_valid=1, tx_data=CTRL_BYTE. On handshake go to WACK with next=CMD; idx=0.
  - CMD: rom_addr=idx, tx_valid=1, tx_data=rom_data, tx_last=(idx==CMD_COUNT-1). On handshake go to WACK with next=CMD, or next=FIN if last.
  - WACK: tx_valid=0; wait for tx_done.
    - tx_done & !tx_nack: go to next; idx increments when leaving a CMD byte.
    - tx_done & tx_nack with retry_cnt<RETRY_MAX: retry_cnt+1; idx=0; go to ADDR (fresh START). No PWR wait on a retry.
    - tx_done & tx_nack with retry_cnt==RETRY_MAX: go to ERROR.
  - FIN: go to DONE next cycle with init_done=1.
  - ERROR: init_err=1.
- Output timing and stability:
  - tx_* outputs are registered.
  - tx_data, tx_first and tx_last are stable while tx_valid=1 and tx_ready=0.
  - tx_valid drops the cycle after the handshake.
  - tx_first and tx_last are 0 whenever tx_valid=0.
- idx is 7 bits and never wraps: CMD_COUNT ≤ 128; the last index is compared explicitly.
- tx_done arriving outside WACK is ignored.
- start while busy is ignored; it does not restart the sequence.
- Latency, no stalls, CMD_COUNT=N: first tx_valid at PWR_WAIT+1 cycles after start. Each byte costs one handshake cycle plus the master's tx_done delay.
- Total bytes per attempt: N+2.

Test Plan:
- Nominal run: reset, start, ready always 1, tx_done 3 cycles after each accept, no NACK → 43 bytes: 0x78, 0x00, then ROM[0..40] in order (0xAE, 0x20, 0x01, …). tx_first only on 0x78, tx_last only on ROM[40]=0x00. init_done=1, busy=0, retry_cnt=0.
- Backpressure: tx_ready held 0 for 5 cycles on byte ROM[8]=0x81 → tx_valid and tx_data=0x81 held unchanged; exactly one accept; byte sequence identical to the nominal run.
- Single NACK on ROM[3] → retry_cnt=1; next byte is 0x78 with tx_first=1; full frame repeats; init_done=1.
- Persistent NACK on the address byte, RETRY_MAX=3 → 4 address attempts, retry_cnt=3, then init_err=1, init_done=0, busy=0, tx_valid=0.
- Reset mid-frame: assert reset while in CMD at idx=10 → all outputs 0 asynchronously. After release plus start, sequence restarts at 0x78 after PWR_WAIT cycles.
- start pulsed during WACK and in DONE → ignored during WACK. In DONE it clears init_done and reruns the full frame.

Source files
------------

// File: rtl/oled_init_seq.sv
// Init sequencer: streams {slave address, control byte, ROM[0..CMD_COUNT-1]} as one I2C write frame, retrying on NACK.
// Latency: first byte offered PWR_WAIT+1 cycles after start; each byte costs one handshake cycle plus the master's ACK delay.
// Backpressure: tx_* held stable while tx_valid & !tx_ready; the next byte is offered only after tx_done of the previous one.
// Ports: ck, reset (async, active-low); start request; rom_addr/rom_data combinational command ROM read;
//        tx_valid/tx_data/tx_first/tx_last/tx_ready/tx_done/tx_nack byte interface to the I2C master;
//        busy, init_done, init_err, retry_cnt status.
module oled_init_seq #(
    parameter int unsigned CMD_COUNT  = 41,
    parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
    parameter logic [7:0]  CTRL_BYTE  = 8'h00,
    parameter int unsigned PWR_WAIT   = 16,
    parameter int unsigned RETRY_MAX  = 3
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       start,
    output logic [6:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_first,
    output logic       tx_last,
    input  logic       tx_ready,
    input  logic       tx_done,
    input  logic       tx_nack,
    output logic       busy,
    output logic       init_done,
    output logic       init_err,
    output logic [1:0] retry_cnt
);
    typedef enum logic [3:0] {
        S_IDLE, S_PWR, S_ADDR, S_CTRL, S_CMD, S_WACK, S_FIN, S_DONE, S_ERROR
    } state_t;

    localparam logic [6:0]  LAST_IDX  = 7'(CMD_COUNT - 1);
    localparam logic [19:0] WAIT_LOAD = 20'(PWR_WAIT - 1);
    localparam logic [1:0]  RETRY_LIM = 2'(RETRY_MAX);
    localparam logic [7:0]  ADDR_BYTE = {SLAVE_ADDR, 1'b0};

    state_t      state_q, state_d;
    state_t      ret_q, ret_d;      // where WACK goes on a clean ACK
    logic [6:0]  idx_q, idx_d;
    logic [19:0] wait_q, wait_d;
    logic [1:0]  retry_d;
    logic        done_d, err_d;
    logic        valid_d, first_d, last_d;
    logic [7:0]  data_d;
    logic        hs;

    assign hs       = tx_valid & tx_ready;
    // idx already points at the next ROM byte while in WACK, so rom_data is
    // valid when the following CMD byte is registered into tx_data.
    assign rom_addr = idx_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            retry_cnt <= '0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            tx_first  <= 1'b0;
            tx_last   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            retry_cnt <= retry_d;
            init_done <= done_d;
            init_err  <= err_d;
            tx_valid  <= valid_d;
            tx_data   <= data_d;
            tx_first  <= first_d;
            tx_last   <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        retry_d = retry_cnt;
        done_d  = init_done;
        err_d   = init_err;
        valid_d = tx_valid;
        data_d  = tx_data;
        first_d = tx_first;
        last_d  = tx_last;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    retry_d = '0;
                    idx_d   = '0;
                    wait_d  = WAIT_LOAD;
                    state_d = S_PWR;
                end
            end
            S_PWR: begin
                if (wait_q == '0) begin
                    state_d = S_ADDR;
                    valid_d = 1'b1;
                    data_d  = ADDR_BYTE;
                    first_d = 1'b1;
                    last_d  = 1'b0;
                end else begin
                    wait_d = wait_q - 20'd1;
                end
            end
            S_ADDR: begin
                if (hs) begin
                    state_d = S_WACK;
                    ret_d   = S_CTRL;
                    valid_d = 1'b0;
                    first_d = 1'b0;
                end
            end
            S_CTRL: begin
                if (hs) begin
                    state_d = S_WACK;
                    ret_d   = S_CMD;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end
            end
            S_CMD: begin
                if (hs) begin
                    state_d = S_WACK;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        ret_d = S_FIN;
                    end else begin
                        ret_d = S_CMD;
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            S_WACK: begin
                if (tx_done) begin
                    if (!tx_nack) begin
                        case (ret_q)
                            S_CTRL: begin
                                state_d = S_CTRL;
                                valid_d = 1'b1;
                                data_d  = CTRL_BYTE;
                            end
                            S_CMD: begin
                                state_d = S_CMD;
                                valid_d = 1'b1;
                                data_d  = rom_data;
                                last_d  = (idx_q == LAST_IDX);
                            end
                            default: state_d = S_FIN;
                        endcase
                    end else if (retry_cnt < RETRY_LIM) begin
                        // Restart the frame with a fresh START; no power-up wait.
                        retry_d = retry_cnt + 2'd1;
                        idx_d   = '0;
                        state_d = S_ADDR;
                        valid_d = 1'b1;
                        data_d  = ADDR_BYTE;
                        first_d = 1'b1;
                        last_d  = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_oled_init_seq.sv
module tb_oled_init_seq;
    localparam int N    = 41;
    localparam int PW   = 16;
    localparam int RMAX = 3;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_first, tx_last;
    logic       tx_ready = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_nack = 1'b0;
    logic       busy, init_done, init_err;
    logic [1:0] retry_cnt;

    logic [7:0] init_bytes [N] = '{
        8'hAE, 8'h20, 8'h01, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h07, 8'h81, 8'hCF,
        8'hA1, 8'hC8, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'hD5, 8'h80, 8'hD9,
        8'hF1, 8'hDA, 8'h12, 8'hDB, 8'h40, 8'h8D, 8'h14, 8'hA4, 8'hA6, 8'h2E,
        8'hB0, 8'h00, 8'h10, 8'hA4, 8'hAF, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3,
        8'h00};
    logic [7:0] rom [128];
    assign rom_data = rom[rom_addr];

    always #5 ck = ~ck;

    oled_init_seq #(
        .CMD_COUNT(N), .SLAVE_ADDR(7'h3C), .CTRL_BYTE(8'h00),
        .PWR_WAIT(PW), .RETRY_MAX(RMAX)
    ) dut (
        .ck(ck), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_first(tx_first), .tx_last(tx_last),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_nack(tx_nack),
        .busy(busy), .init_done(init_done), .init_err(init_err), .retry_cnt(retry_cnt)
    );

    // Slave/master model configuration
    int  ready_mode;   // 0 always ready, 1 random, 2 stall 5 cycles at stall_pos
    int  done_delay;   // <0: random 0..4 cycles
    int  stall_pos;
    int  nack_at [4];  // per attempt: frame position that gets NACKed, -1 none
    bit  spur_en;      // spurious tx_done pulses while a byte is pending acceptance

    logic [7:0] got_dat [$];
    logic       got_first [$];
    logic       got_last [$];
    logic [7:0] exp_dat [$];
    logic       exp_first [$];
    logic       exp_last [$];
    int n_first, cur_pos, proto_err, stall_hits, stall_bad;
    bit stall_done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int rmode; int delay; int stall;
        int nk0; int nk1; int nk2; int nk3; bit spur;
        int e_len; int e_done; int e_err; int e_retry;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // I2C master stand-in: accepts bytes, returns tx_done after a delay,
    // NACKs according to nack_at, and watches the byte interface rules.
    initial begin : slave
        bit pend, pend_nack, prev_stall, prev_first, prev_last;
        int pend_cnt, stall_left, pos, att;
        logic [7:0] prev_dat;
        pend = 0; pend_nack = 0; prev_stall = 0; prev_first = 0; prev_last = 0;
        pend_cnt = 0; stall_left = 0; pos = 0; att = 0; prev_dat = '0;
        forever begin
            @(negedge ck);
            if (!reset) begin
                pend = 0; prev_stall = 0; stall_left = 0;
                tx_ready = 0; tx_done = 0; tx_nack = 0;
                continue;
            end
            tx_done = 0;
            tx_nack = 0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    tx_done = 1; tx_nack = pend_nack; pend = 0;
                end else begin
                    pend_cnt--;
                end
            end
            if (!tx_valid && (tx_first || tx_last)) proto_err++;
            if (prev_stall && !(tx_valid && tx_data === prev_dat &&
                                tx_first === prev_first && tx_last === prev_last)) proto_err++;
            tx_ready = 0;
            if (tx_valid) begin
                pos = tx_first ? 0 : cur_pos + 1;
                if (pos >= 2 && rom_addr !== 7'(pos - 2)) proto_err++;
                case (ready_mode)
                    0: tx_ready = 1;
                    1: tx_ready = ($urandom_range(0, 2) != 0);
                    default: begin
                        if (pos == stall_pos && !stall_done) begin
                            stall_left = 5; stall_done = 1;
                        end
                        if (stall_left > 0) begin
                            stall_left--; stall_hits++;
                            if (tx_data !== 8'h81) stall_bad++;
                            tx_ready = 0;
                        end else begin
                            tx_ready = 1;
                        end
                    end
                endcase
                if (tx_ready) begin
                    got_dat.push_back(tx_data);
                    got_first.push_back(tx_first);
                    got_last.push_back(tx_last);
                    if (tx_first) n_first++;
                    cur_pos = pos;
                    att = n_first - 1;
                    if (pend) proto_err++;
                    pend = 1;
                    pend_nack = (att >= 0 && att < 4 && nack_at[att] == pos);
                    pend_cnt = (done_delay < 0) ? int'($urandom_range(0, 4)) : done_delay;
                end else if (spur_en && !pend && $urandom_range(0, 3) == 0) begin
                    tx_done = 1;
                    tx_nack = 1'($urandom_range(0, 1));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_dat   = tx_data;
            prev_first = tx_first;
            prev_last  = tx_last;
        end
    end

    task automatic clear_rec();
        got_dat.delete(); got_first.delete(); got_last.delete();
        n_first = 0; cur_pos = -1; proto_err = 0;
        stall_hits = 0; stall_bad = 0; stall_done = 0;
    endtask

    task automatic apply_cfg(input vec_t v);
        ready_mode = v.rmode; done_delay = v.delay; stall_pos = v.stall; spur_en = v.spur;
        nack_at[0] = v.nk0; nack_at[1] = v.nk1; nack_at[2] = v.nk2; nack_at[3] = v.nk3;
    endtask

    // Pulse start for one cycle; lat = cycles until the first byte is offered.
    task automatic launch(output int lat);
        @(negedge ck);
        start = 1;
        lat = 0;
        do begin
            @(negedge ck);
            start = 0;
            lat++;
        end while (!tx_valid && lat < PW + 50);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge ck);
            n++;
        end
        check({tag, ".finished"}, busy, 0);
    endtask

    // Frame-level reference: each attempt sends addr, ctrl, ROM bytes until
    // the NACKed position (if any); retries until RMAX restarts are used.
    task automatic model(output int e_done, output int e_err, output int e_retry);
        int att;
        bit nk;
        logic [7:0] b;
        exp_dat.delete(); exp_first.delete(); exp_last.delete();
        att = 0;
        e_done = 0; e_err = 0;
        while (1) begin
            nk = 0;
            for (int p = 0; p < N + 2; p++) begin
                b = (p == 0) ? 8'h78 : (p == 1) ? 8'h00 : rom[p - 2];
                exp_dat.push_back(b);
                exp_first.push_back(p == 0);
                exp_last.push_back(p == N + 1);
                if (nack_at[att] == p) begin
                    nk = 1;
                    break;
                end
            end
            if (!nk) begin e_done = 1; break; end
            if (att == RMAX) begin e_err = 1; break; end
            att++;
        end
        e_retry = att;
    endtask

    task automatic verify(input string tag, input int e_len, input int e_done,
                          input int e_err, input int e_retry);
        int mism, first_bad;
        mism = 0;
        first_bad = -1;
        check({tag, ".len"}, got_dat.size(), e_len);
        for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++) begin
            if (got_dat[i] !== exp_dat[i] || got_first[i] !== exp_first[i] ||
                got_last[i] !== exp_last[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check({tag, ".stream_mismatches"}, mism, 0);
        if (first_bad >= 0)
            $display("  first differing byte at %0d: got 0x%0h exp 0x%0h",
                     first_bad, got_dat[first_bad], exp_dat[first_bad]);
        check({tag, ".init_done"}, init_done, e_done);
        check({tag, ".init_err"}, init_err, e_err);
        check({tag, ".retry_cnt"}, retry_cnt, e_retry);
        check({tag, ".tx_valid_idle"}, tx_valid, 0);
        check({tag, ".protocol"}, proto_err, 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs [7];
        vec_t nom;
        int lat, m_done, m_err, m_retry, n;
        string tag;

        for (int i = 0; i < 128; i++) rom[i] = (i < N) ? init_bytes[i] : 8'hEE;

        //            rmode dly stall nk0 nk1 nk2 nk3 spur len done err retry
        vecs[0] = '{0, 3, -1, -1, -1, -1, -1, 1'b0,  43, 1, 0, 0}; // nominal
        vecs[1] = '{2, 3, 10, -1, -1, -1, -1, 1'b0,  43, 1, 0, 0}; // stall on ROM[8]
        vecs[2] = '{0, 3, -1,  5, -1, -1, -1, 1'b0,  49, 1, 0, 1}; // NACK on ROM[3]
        vecs[3] = '{0, 3, -1,  0,  0,  0,  0, 1'b0,   4, 0, 1, 3}; // address always NACKed
        vecs[4] = '{0, 1, -1, 42, 42, -1, -1, 1'b0, 129, 1, 0, 2}; // last byte NACKed twice
        vecs[5] = '{0, 0, -1,  1,  1,  1, -1, 1'b0,  49, 1, 0, 3}; // ctrl NACKed, last retry ok
        vecs[6] = '{1, -1, -1, 20, -1, -1, -1, 1'b1, 64, 1, 0, 1}; // random ready, spurious tx_done
        nom = vecs[0];

        apply_cfg(nom);
        clear_rec();
        #1 reset = 0;
        #2;
        check("reset.outputs_zero",
              32'({rom_addr, tx_valid, tx_data, tx_first, tx_last, busy, init_done, init_err, retry_cnt}), 0);
        repeat (2) @(negedge ck);
        reset = 1;
        @(negedge ck);
        check("reset.still_idle", 32'({busy, tx_valid, init_done, init_err}), 0);

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("vec%0d", i);
            apply_cfg(vecs[i]);
            clear_rec();
            launch(lat);
            check({tag, ".first_valid_latency"}, lat, PW + 1);
            wait_idle(tag);
            model(m_done, m_err, m_retry);
            verify(tag, vecs[i].e_len, vecs[i].e_done, vecs[i].e_err, vecs[i].e_retry);
            if (vecs[i].rmode == 2) begin
                check({tag, ".stall_cycles"}, stall_hits, 5);
                check({tag, ".stall_data_81"}, stall_bad, 0);
            end
        end

        // start while waiting for an ACK must be ignored
        apply_cfg(nom);
        clear_rec();
        launch(lat);
        n = 0;
        while (!(cur_pos == 2 && !tx_valid && busy) && n < 500) begin
            @(negedge ck);
            n++;
        end
        check("wack.reached", (cur_pos == 2 && !tx_valid && busy), 1);
        start = 1;
        @(negedge ck);
        start = 0;
        wait_idle("wack_start");
        model(m_done, m_err, m_retry);
        verify("wack_start", 43, 1, 0, 0);

        // start in DONE clears init_done and reruns the frame
        check("done.before_restart", init_done, 1);
        clear_rec();
        launch(lat);
        check("done.cleared_on_start", init_done, 0);
        check("done.restart_latency", lat, PW + 1);
        wait_idle("done_restart");
        verify("done_restart", 43, 1, 0, 0);

        // asynchronous reset while sending ROM[10]
        clear_rec();
        launch(lat);
        n = 0;
        while (!(tx_valid && rom_addr == 7'd10 && got_dat.size() >= 3) && n < 500) begin
            @(negedge ck);
            n++;
        end
        check("midreset.reached_idx10", (tx_valid && rom_addr == 7'd10), 1);
        #2 reset = 0;
        #1;
        check("midreset.outputs_zero",
              32'({rom_addr, tx_valid, tx_data, tx_first, tx_last, busy, init_done, init_err, retry_cnt}), 0);
        repeat (2) @(negedge ck);
        reset = 1;
        clear_rec();
        launch(lat);
        check("midreset.restart_latency", lat, PW + 1);
        wait_idle("midreset");
        verify("midreset", 43, 1, 0, 0);

        // randomized frames against the reference model
        for (int r = 0; r < 6; r++) begin
            tag = $sformatf("rand%0d", r);
            ready_mode = 1;
            done_delay = -1;
            spur_en = 1;
            stall_pos = -1;
            for (int a = 0; a < 4; a++)
                nack_at[a] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N + 1)) : -1;
            clear_rec();
            launch(lat);
            check({tag, ".first_valid_latency"}, lat, PW + 1);
            wait_idle(tag);
            model(m_done, m_err, m_retry);
            verify(tag, exp_dat.size(), m_done, m_err, m_retry);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
